// File: rtl/pwm_array_if.sv
// rtl/pwm_array_if.sv - line-sync, duty and PWM output bundle for pwm_array
interface pwm_array_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      hsync;
  logic                      mode;
  logic [CHANNELS*WIDTH-1:0] data;
  logic [CHANNELS-1:0]       out;
  logic                      period_end;
  logic [WIDTH-1:0]          cnt;

  modport master (output hsync, mode, data, input out, period_end, cnt);
  modport slave  (input hsync, mode, data, output out, period_end, cnt);
endinterface

// File: rtl/pwm_array.sv
// rtl/pwm_array.sv - line-synchronous multi-channel PWM with double-buffered duty
module pwm_array #(
  parameter int WIDTH           = 8,
  parameter int CHANNELS        = 4,
  parameter int LATCH_ON_PERIOD = 1
) (
  input  logic        clk,
  input  logic        rst,
  pwm_array_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  dir_t                dir_q, dir_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic                hsync_d;
  logic [WIDTH-1:0]    duty_q [CHANNELS];
  logic [WIDTH-1:0]    duty_d [CHANNELS];
  logic                mode_q, mode_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                pe_q, pe_d;
  logic                line_start, running, pe_cond, reload;

  always_comb begin
    line_start = bus.hsync && !hsync_d;
    running    = bus.hsync && hsync_d;
    pe_cond    = running && (mode_q ? (dir_q == DOWN && cnt_q == ONE) : (cnt_q == MAX));
    reload     = line_start || ((LATCH_ON_PERIOD != 0) && pe_cond);

    cnt_d  = '0;
    dir_d  = UP;
    mode_d = mode_q;
    duty_d = duty_q;

    if (running) begin
      if (!mode_q) begin
        cnt_d = cnt_q + ONE;
      end else if (dir_q == UP) begin
        if (cnt_q == MAX) begin
          cnt_d = MAX - ONE;
          dir_d = DOWN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else if (cnt_q != ONE) begin
        cnt_d = cnt_q - ONE;
        dir_d = DOWN;
      end
    end

    // Reload lands on the same edge the counter returns to 0, so a new duty
    // always starts on a fresh period.
    if (reload) begin
      mode_d = bus.mode;
      for (int i = 0; i < CHANNELS; i++) duty_d[i] = bus.data[i*WIDTH +: WIDTH];
      if (line_start || (bus.mode != mode_q)) begin
        cnt_d = '0;
        dir_d = UP;
      end
    end

    for (int i = 0; i < CHANNELS; i++) out_d[i] = running && (cnt_q < duty_q[i]);
    pe_d = pe_cond;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      dir_q   <= UP;
      hsync_d <= 1'b0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      pe_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      hsync_d <= bus.hsync;
      mode_q  <= mode_d;
      out_q   <= out_d;
      pe_q    <= pe_d;
      for (int i = 0; i < CHANNELS; i++) duty_q[i] <= duty_d[i];
    end
  end

  assign bus.out        = out_q;
  assign bus.period_end = pe_q;
  assign bus.cnt        = cnt_q;
endmodule

// File: tb/tb_pwm_array.sv
// tb/tb_pwm_array.sv - directed self-checking bench for pwm_array (both reload options)
module tb_pwm_array;
  logic        clk = 1'b0;
  logic        rst;
  logic        hsync;
  logic        mode;
  logic [31:0] data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pwm_array_if #(.WIDTH(8), .CHANNELS(4)) bus1 ();
  pwm_array_if #(.WIDTH(8), .CHANNELS(4)) bus0 ();

  assign bus1.hsync = hsync;
  assign bus1.mode  = mode;
  assign bus1.data  = data;
  assign bus0.hsync = hsync;
  assign bus0.mode  = mode;
  assign bus0.data  = data;

  pwm_array #(.WIDTH(8), .CHANNELS(4), .LATCH_ON_PERIOD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pwm_array #(.WIDTH(8), .CHANNELS(4), .LATCH_ON_PERIOD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; hsync = 1'b0; mode = 1'b0; data = '0;
    repeat (5) tick();
    checks++; if (bus1.out !== 4'b0000) begin failures++; $display("FAIL rst_out got=%b exp=0000", bus1.out); end
    checks++; if (bus1.cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", bus1.cnt); end
    checks++; if (bus1.period_end !== 1'b0) begin failures++; $display("FAIL rst_pe got=%b exp=0", bus1.period_end); end
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus1.out !== 4'b0000 || bus0.out !== 4'b0000) begin failures++; $display("FAIL idle_out got=%b/%b exp=0000", bus1.out, bus0.out); end
    checks++; if (bus1.cnt !== 8'd0 || bus1.period_end !== 1'b0) begin failures++; $display("FAIL idle_cnt_pe got=%0d/%b exp=0/0", bus1.cnt, bus1.period_end); end
  endtask

  task automatic test_left;
    int hi [4];
    int pe_n, pe_first, pe_second;
    hi = '{0, 0, 0, 0}; pe_n = 0; pe_first = -1; pe_second = -1;
    data = {8'd255, 8'd128, 8'd0, 8'd20}; mode = 1'b0; hsync = 1'b1;
    tick();
    checks++; if (bus1.out !== 4'b0000 || bus1.cnt !== 8'd0) begin failures++; $display("FAIL left_start got=%b/%0d exp=0000/0", bus1.out, bus1.cnt); end
    tick();
    checks++; if (bus1.out !== 4'b1101) begin failures++; $display("FAIL left_first_out got=%b exp=1101", bus1.out); end
    for (int i = 0; i < 512; i++) begin
      for (int c = 0; c < 4; c++) if (bus1.out[c]) hi[c]++;
      if (bus1.period_end) begin
        if (pe_n == 0) pe_first = i; else if (pe_n == 1) pe_second = i;
        pe_n++;
      end
      tick();
    end
    checks++; if (hi[0] != 40) begin failures++; $display("FAIL left_ch0_high got=%0d exp=40", hi[0]); end
    checks++; if (hi[1] != 0) begin failures++; $display("FAIL left_ch1_high got=%0d exp=0", hi[1]); end
    checks++; if (hi[2] != 256) begin failures++; $display("FAIL left_ch2_high got=%0d exp=256", hi[2]); end
    checks++; if (hi[3] != 510) begin failures++; $display("FAIL left_ch3_high got=%0d exp=510", hi[3]); end
    checks++; if (pe_n != 2 || pe_first != 255 || pe_second != 511) begin failures++; $display("FAIL left_pe got=%0d@%0d,%0d exp=2@255,511", pe_n, pe_first, pe_second); end
    hsync = 1'b0;
    tick();
    checks++; if (bus1.out !== 4'b0000 || bus1.cnt !== 8'd0 || bus1.period_end !== 1'b0) begin failures++; $display("FAIL left_idle got=%b/%0d/%b exp=0000/0/0", bus1.out, bus1.cnt, bus1.period_end); end
  endtask

  task automatic test_center;
    int hi0, hi2, pe_n, pe_first, pe_second, bad_pe, max_cnt;
    hi0 = 0; hi2 = 0; pe_n = 0; pe_first = -1; pe_second = -1; bad_pe = 0; max_cnt = 0;
    data = {8'd0, 8'd1, 8'd0, 8'd100}; mode = 1'b1; hsync = 1'b1;
    tick();
    tick();
    checks++; if (bus1.out[0] !== 1'b1) begin failures++; $display("FAIL center_first_out got=%b exp=1", bus1.out[0]); end
    for (int i = 0; i < 1020; i++) begin
      if (bus1.out[0]) hi0++;
      if (bus1.out[2]) hi2++;
      if (int'(bus1.cnt) > max_cnt) max_cnt = int'(bus1.cnt);
      if (bus1.period_end) begin
        if (bus1.cnt !== 8'd0) bad_pe++;
        if (pe_n == 0) pe_first = i; else if (pe_n == 1) pe_second = i;
        pe_n++;
      end
      tick();
    end
    checks++; if (hi0 != 398) begin failures++; $display("FAIL center_ch0_high got=%0d exp=398", hi0); end
    checks++; if (hi2 != 2) begin failures++; $display("FAIL center_ch2_high got=%0d exp=2", hi2); end
    checks++; if (pe_n != 2 || pe_first != 509 || pe_second != 1019) begin failures++; $display("FAIL center_pe got=%0d@%0d,%0d exp=2@509,1019", pe_n, pe_first, pe_second); end
    checks++; if (bad_pe != 0) begin failures++; $display("FAIL center_pe_cnt0 got=%0d exp=0", bad_pe); end
    checks++; if (max_cnt != 255) begin failures++; $display("FAIL center_max_cnt got=%0d exp=255", max_cnt); end
    hsync = 1'b0;
    tick();
  endtask

  task automatic test_reload;
    int hi1 [2];
    int hi0 [2];
    bit changed;
    hi1 = '{0, 0}; hi0 = '{0, 0}; changed = 1'b0;
    data = {8'd0, 8'd0, 8'd0, 8'd20}; mode = 1'b0; hsync = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 512; i++) begin
      if (bus1.out[0]) hi1[i/256]++;
      if (bus0.out[0]) hi0[i/256]++;
      if (!changed && bus1.cnt == 8'd50) begin
        data[7:0] = 8'd200;
        changed = 1'b1;
      end
      tick();
    end
    checks++; if (!changed) begin failures++; $display("FAIL reload_saw_cnt50 got=0 exp=1"); end
    checks++; if (hi1[0] != 20 || hi1[1] != 200) begin failures++; $display("FAIL reload_latch1 got=%0d,%0d exp=20,200", hi1[0], hi1[1]); end
    checks++; if (hi0[0] != 20 || hi0[1] != 20) begin failures++; $display("FAIL reload_latch0 got=%0d,%0d exp=20,20", hi0[0], hi0[1]); end
  endtask

  task automatic test_hsync_gap;
    int n, hi1, hi0, pe1, pe0;
    n = 0; hi1 = 0; hi0 = 0; pe1 = -1; pe0 = -1;
    while (bus1.cnt != 8'd77 && n < 300) begin tick(); n++; end
    checks++; if (bus1.cnt !== 8'd77) begin failures++; $display("FAIL gap_wait_cnt77 got=%0d exp=77", bus1.cnt); end
    data[7:0] = 8'd30; mode = 1'b1; hsync = 1'b0;
    tick();
    checks++; if (bus1.out !== 4'b0000 || bus0.out !== 4'b0000) begin failures++; $display("FAIL gap_out got=%b/%b exp=0000", bus1.out, bus0.out); end
    checks++; if (bus1.cnt !== 8'd0 || bus0.cnt !== 8'd0) begin failures++; $display("FAIL gap_cnt got=%0d/%0d exp=0", bus1.cnt, bus0.cnt); end
    hsync = 1'b1;
    tick();
    checks++; if (bus1.cnt !== 8'd0 || bus0.cnt !== 8'd0 || bus1.out !== 4'b0000) begin failures++; $display("FAIL gap_restart got=%0d/%0d/%b exp=0/0/0000", bus1.cnt, bus0.cnt, bus1.out); end
    tick();
    for (int i = 0; i < 510; i++) begin
      if (bus1.out[0]) hi1++;
      if (bus0.out[0]) hi0++;
      if (bus1.period_end && pe1 < 0) pe1 = i;
      if (bus0.period_end && pe0 < 0) pe0 = i;
      tick();
    end
    checks++; if (hi1 != 59 || hi0 != 59) begin failures++; $display("FAIL gap_fresh_duty got=%0d/%0d exp=59", hi1, hi0); end
    checks++; if (pe1 != 509 || pe0 != 509) begin failures++; $display("FAIL gap_fresh_mode got=%0d/%0d exp=509", pe1, pe0); end
  endtask

  task automatic test_async_reset;
    int hi;
    hi = 0;
    checks++; if (bus1.out[0] !== 1'b1 || bus1.cnt === 8'd0) begin failures++; $display("FAIL arst_pre got=%b/%0d exp=1/nonzero", bus1.out[0], bus1.cnt); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus1.out !== 4'b0000 || bus0.out !== 4'b0000) begin failures++; $display("FAIL arst_out got=%b/%b exp=0000", bus1.out, bus0.out); end
    checks++; if (bus1.cnt !== 8'd0 || bus1.period_end !== 1'b0) begin failures++; $display("FAIL arst_cnt_pe got=%0d/%b exp=0/0", bus1.cnt, bus1.period_end); end
    data = '0;
    repeat (3) tick();
    checks++; if (bus1.out !== 4'b0000 || bus1.cnt !== 8'd0) begin failures++; $display("FAIL arst_hold got=%b/%0d exp=0000/0", bus1.out, bus1.cnt); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus1.out != 4'b0000) hi++;
      if (bus0.out != 4'b0000) hi++;
    end
    checks++; if (hi != 0) begin failures++; $display("FAIL arst_release_out got=%0d exp=0", hi); end
    checks++; if (bus1.cnt !== 8'd211) begin failures++; $display("FAIL arst_release_cnt got=%0d exp=211", bus1.cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_left();
    test_center();
    test_reload();
    test_hsync_gap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
